// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the RV32I run-control sequencer.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_STEP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_BREAK = 2'd3
  } run_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned PC_W                = 32;

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer plus stability-counter debouncer for one board input.
// The level is accepted once the synchronized value differs for CYCLES+1 edges.
module input_debounce
  import run_ctrl_pkg::*;
#(
  parameter int unsigned CYCLES  = DEBOUNCE_CYCLES_DEF,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any return to the accepted level restarts the stability window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_level <= RST_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_fall  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/run_ctrl.sv
// Run-control sequencer: halt / single-step / free-run with a PC breakpoint,
// producing the per-cycle core enable and a retired-instruction counter.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step_n,
  input  logic             sw_run,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_en,
  output logic             halted,
  output logic             bp_hit,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instret
);

  logic w_run_s;
  logic w_run_rise;
  logic w_run_fall;
  logic w_btn_lvl;
  logic w_btn_rise;
  logic w_step_pulse;
  logic w_unused_edges;

  input_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_db_step (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (btn_step_n),
    .o_level (w_btn_lvl),
    .o_rise  (w_btn_rise),
    .o_fall  (w_step_pulse)
  );

  input_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db_run (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (sw_run),
    .o_level (w_run_s),
    .o_rise  (w_run_rise),
    .o_fall  (w_run_fall)
  );

  assign w_unused_edges = w_btn_lvl ^ w_btn_rise ^ w_run_rise ^ w_run_fall;

  run_state_t       r_state;
  run_state_t       w_next;
  logic             r_first;
  logic             w_first_nxt;
  logic             r_bp_hit;
  logic             w_bp_hit_nxt;
  logic             r_armed;
  logic             w_armed_nxt;
  logic             r_halted;
  logic [CNT_W-1:0] r_instret;
  logic             w_cpu_en;
  logic             w_bp_match;

  assign w_bp_match = bp_en && (pc == bp_addr);

  // r_armed blocks a HALT->RUN restart after a breakpoint until run_s has been low.
  always_comb begin
    w_next       = r_state;
    w_cpu_en     = 1'b0;
    w_first_nxt  = r_first;
    w_bp_hit_nxt = r_bp_hit;
    w_armed_nxt  = r_armed | ~w_run_s;
    case (r_state)
      ST_HALT: begin
        if (w_run_s) begin
          if (r_armed) begin
            w_next       = ST_RUN;
            w_first_nxt  = 1'b1;
            w_bp_hit_nxt = 1'b0;
          end
        end else if (w_step_pulse) begin
          w_next       = ST_STEP;
          w_bp_hit_nxt = 1'b0;
        end
      end
      ST_STEP: begin
        w_cpu_en = 1'b1;
        w_next   = ST_HALT;
      end
      ST_RUN: begin
        if (!w_run_s) begin
          w_next = ST_HALT;
        end else if (w_bp_match && !r_first) begin
          w_next       = ST_BREAK;
          w_bp_hit_nxt = 1'b1;
          w_armed_nxt  = 1'b0;
        end else begin
          w_cpu_en    = 1'b1;
          w_first_nxt = 1'b0;
        end
      end
      ST_BREAK: begin
        if (!w_run_s) begin
          w_next = ST_HALT;
        end else if (w_step_pulse) begin
          w_next       = ST_STEP;
          w_bp_hit_nxt = 1'b0;
        end
      end
      default: w_next = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_HALT;
      r_first  <= 1'b0;
      r_bp_hit <= 1'b0;
      r_armed  <= 1'b1;
      r_halted <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_first  <= w_first_nxt;
      r_bp_hit <= w_bp_hit_nxt;
      r_armed  <= w_armed_nxt;
      r_halted <= (w_next == ST_HALT) || (w_next == ST_BREAK);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instret <= '0;
    end else if (w_cpu_en) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign cpu_en  = w_cpu_en;
  assign halted  = r_halted;
  assign bp_hit  = r_bp_hit;
  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized and directed bench for run_ctrl against a cycle-level behavioural model.
module tb_run_ctrl;

  localparam int unsigned DB = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_step_n;
  logic        sw_run;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_en, halted, bp_hit;
  logic [1:0]  state;
  logic [31:0] instret;
  logic        cpu_en4, halted4, bp_hit4;
  logic [1:0]  state4;
  logic [3:0]  instret4;

  always #5 clk = ~clk;

  run_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .btn_step_n(btn_step_n), .sw_run(sw_run),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en),
    .halted(halted), .bp_hit(bp_hit), .state(state), .instret(instret)
  );

  run_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .btn_step_n(btn_step_n), .sw_run(sw_run),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en4),
    .halted(halted4), .bp_hit(bp_hit4), .state(state4), .instret(instret4)
  );

  // Behavioural model state
  int          m_state;
  bit          m_first, m_bp_hit, m_need_rearm;
  bit          m_run_s, m_btn_lvl, m_step;
  logic [31:0] m_instret, m_pc;
  bit          sw_hist[$];
  bit          btn_hist[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          dut_en_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_en();
    if (m_state == 1) return 1'b1;
    if (m_state == 2)
      return m_run_s && !(bp_en && (pc == bp_addr) && !m_first);
    return 1'b0;
  endfunction

  // Level flips when the last DB+1 synchronizer outputs all disagree with it.
  function automatic bit window_flips(input bit q[$], input bit lvl);
    if (q.size() < DB + 3) return 1'b0;
    for (int i = 0; i <= int'(DB); i++)
      if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_first = 0; m_bp_hit = 0; m_need_rearm = 0;
    m_run_s = 0; m_btn_lvl = 1; m_step = 0;
    m_instret = '0; m_pc = '0;
    sw_hist.delete(); btn_hist.delete();
    for (int i = 0; i < int'(DB) + 3; i++) begin
      sw_hist.push_back(1'b0);
      btn_hist.push_back(1'b1);
    end
  endtask

  task automatic model_edge();
    bit en;
    bit flip_btn;
    if (!reset) begin
      model_reset();
      return;
    end
    en = model_en();
    if (!m_run_s) m_need_rearm = 0;
    if (m_state == 0) begin
      if (m_run_s && !m_need_rearm) begin
        m_state = 2; m_first = 1; m_bp_hit = 0;
      end else if (!m_run_s && m_step) begin
        m_state = 1; m_bp_hit = 0;
      end
    end else if (m_state == 1) begin
      m_state = 0;
    end else if (m_state == 2) begin
      if (!m_run_s) m_state = 0;
      else if (en) m_first = 0;
      else begin
        m_state = 3; m_bp_hit = 1; m_need_rearm = 1;
      end
    end else begin
      if (!m_run_s) m_state = 0;
      else if (m_step) begin
        m_state = 1; m_bp_hit = 0;
      end
    end
    if (en) begin
      m_instret = m_instret + 32'd1;
      m_pc      = m_pc + 32'd4;
    end
    sw_hist.push_back(sw_run);
    btn_hist.push_back(btn_step_n);
    while (sw_hist.size() > DB + 3) void'(sw_hist.pop_front());
    while (btn_hist.size() > DB + 3) void'(btn_hist.pop_front());
    if (window_flips(sw_hist, m_run_s)) m_run_s = !m_run_s;
    flip_btn = window_flips(btn_hist, m_btn_lvl);
    m_step = 0;
    if (flip_btn) begin
      m_btn_lvl = !m_btn_lvl;
      m_step    = !m_btn_lvl;
    end
  endtask

  task automatic compare();
    if (cpu_en === 1'b1) dut_en_cnt++;
    check_eq("cpu_en",   32'(cpu_en),   32'(model_en()));
    check_eq("cpu_en4",  32'(cpu_en4),  32'(model_en()));
    check_eq("state",    32'(state),    m_state);
    check_eq("halted",   32'(halted),   32'(m_state == 0 || m_state == 3));
    check_eq("bp_hit",   32'(bp_hit),   32'(m_bp_hit));
    check_eq("instret",  instret,       m_instret);
    check_eq("instret4", 32'(instret4), 32'(m_instret[3:0]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1 pc = m_pc;
    @(negedge clk);
    compare();
  endtask

  task automatic wait_n(input int unsigned n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b0; sw_run = 1'b0; btn_step_n = 1'b1;
    wait_n(5);
    reset = 1'b1;
    wait_n(2);
  endtask

  task automatic press();
    btn_step_n = 1'b0; wait_n(30);
    btn_step_n = 1'b1; wait_n(30);
  endtask

  initial begin
    int n;
    reset = 1'b0; btn_step_n = 1'b1; sw_run = 1'b0;
    bp_en = 1'b0; bp_addr = '0; pc = '0;
    model_reset();

    // Reset values
    wait_n(5);
    check_eq("rst_state",   32'(state),   32'd0);
    check_eq("rst_halted",  32'(halted),  32'd1);
    check_eq("rst_cpu_en",  32'(cpu_en),  32'd0);
    check_eq("rst_instret", instret,      32'd0);
    check_eq("rst_bp_hit",  32'(bp_hit),  32'd0);
    reset = 1'b1;
    wait_n(2);

    // Asynchronous reset mid-run
    sw_run = 1'b1;
    wait_n(25);
    check_eq("run_before_rst", 32'(cpu_en), 32'd1);
    #2 reset = 1'b0; sw_run = 1'b0;
    #1 check_eq("rst_async_cpu_en", 32'(cpu_en), 32'd0);
    check_eq("rst_async_instret", instret, 32'd0);
    wait_n(5);
    reset = 1'b1;
    wait_n(2);

    // Bouncing step press yields exactly one step
    dut_en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      btn_step_n = ~btn_step_n;
      wait_n(3);
    end
    btn_step_n = 1'b0; wait_n(40);
    btn_step_n = 1'b1; wait_n(30);
    check_eq("bounce_pulses",  32'(dut_en_cnt), 32'd1);
    check_eq("bounce_instret", instret,         32'd1);
    press();
    check_eq("clean_instret",  instret,         32'd2);

    // Free-run throughput and stop latency
    sw_run = 1'b1;
    wait_n(40);
    dut_en_cnt = 0;
    wait_n(10);
    check_eq("run_throughput", 32'(dut_en_cnt), 32'd10);
    sw_run = 1'b0;
    n = 0;
    while (cpu_en === 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    check_eq("stop_latency", n, 32'd19);
    wait_n(3);
    check_eq("stop_state", 32'(state), 32'd0);

    // Breakpoint stop, step off it, no restart until the switch is cycled
    do_reset();
    bp_en = 1'b1; bp_addr = 32'h10;
    sw_run = 1'b1;
    wait_n(40);
    check_eq("bp_state",   32'(state),  32'd3);
    check_eq("bp_flag",    32'(bp_hit), 32'd1);
    check_eq("bp_instret", instret,     32'd4);
    check_eq("bp_cpu_en",  32'(cpu_en), 32'd0);
    press();
    check_eq("bp_step_state",   32'(state),  32'd0);
    check_eq("bp_step_flag",    32'(bp_hit), 32'd0);
    check_eq("bp_step_instret", instret,     32'd5);
    wait_n(20);
    check_eq("bp_no_restart", 32'(state), 32'd0);
    sw_run = 1'b0; wait_n(30);
    sw_run = 1'b1; wait_n(30);
    check_eq("bp_rearm_run", 32'(state), 32'd2);
    sw_run = 1'b0; wait_n(30);

    // Run started on the breakpoint executes that instruction
    do_reset();
    bp_en = 1'b0;
    repeat (4) press();
    check_eq("sob_pre_instret", instret, 32'd4);
    bp_en = 1'b1; bp_addr = 32'h10;
    sw_run = 1'b1;
    n = 0;
    while (cpu_en !== 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    check_eq("sob_first_en", 32'(cpu_en), 32'd1);
    check_eq("sob_state",    32'(state),  32'd2);
    wait_n(10);
    check_eq("sob_no_break", 32'(state),  32'd2);
    check_eq("sob_bp_hit",   32'(bp_hit), 32'd0);
    sw_run = 1'b0; wait_n(30);

    // Narrow counter wraps after 17 steps
    do_reset();
    bp_en = 1'b0;
    repeat (17) press();
    check_eq("wrap_instret4", 32'(instret4), 32'd1);
    check_eq("wrap_instret",  instret,       32'd17);

    // Randomized stimulus against the model
    do_reset();
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          int nb;
          nb = int'($urandom_range(1, 6));
          for (int k = 0; k < nb; k++) begin
            btn_step_n = ~btn_step_n;
            wait_n($urandom_range(1, 8));
          end
          btn_step_n = 1'($urandom_range(0, 1));
          wait_n($urandom_range(5, 40));
        end
        1: begin
          sw_run = ~sw_run;
          wait_n($urandom_range(5, 40));
        end
        2: begin
          if (m_state == 0) begin
            bp_en   = 1'($urandom_range(0, 1));
            bp_addr = m_pc + 32'(4 * $urandom_range(0, 12));
          end
          wait_n(2);
        end
        3: wait_n($urandom_range(1, 30));
        4: begin
          reset = 1'b0;
          wait_n($urandom_range(1, 4));
          reset = 1'b1;
          wait_n(1);
        end
        default: press();
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run-control sequencer for the single-cycle RV32I core on the DE10-Lite. Replaces manual clocking with a free-running `clk` and a per-cycle `cpu_en` enable that gates every core state update: PC, register-file write and data-memory write. Debounced board inputs select halt, single-step or free-run. A PC breakpoint stops free-run, and a retired-instruction counter drives the debug displays.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles a synchronized input must hold stable before its level is accepted (10 ms at 50 MHz).
- `CNT_W`, default 32: width of `instret`.

- `clk`  in  1  system clock, shared with the core.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_step_n`  in  1  raw step push-button, active-low, asynchronous to `clk`.
- `sw_run`  in  1  raw run switch, asynchronous; 1 = free-run.
- `bp_en`  in  1  breakpoint enable, static during run.
- `bp_addr`  in  32  breakpoint PC.
- `pc`  in  32  current core PC (PC register output).
- `cpu_en`  out  1  core update enable for this cycle.
- `halted`  out  1  1 in HALT or BREAK.
- `bp_hit`  out  1  sticky breakpoint flag.
- `state`  out  2  current FSM state, for LEDs.
- `instret`  out  CNT_W  count of cycles with `cpu_en`=1.

## Operation
**Input conditioning**
- Each raw input passes through a 2-FF synchronizer and then a debouncer.
- `step_pulse`: a 1-cycle pulse on each debounced falling edge of `btn_step_n`.
- `run_s`: the debounced level of `sw_run`.

**FSM states:** HALT=0, STEP=1, RUN=2, BREAK=3.
- HALT
  - `run_s`=1 → RUN, with the `first` flag set.
  - Else `step_pulse` → STEP.
  - `run_s` has priority; `step_pulse` is ignored while `run_s`=1.
- STEP
  - `cpu_en`=1 for exactly one cycle, then → HALT unconditionally.
  - Clears `bp_hit` on entry.
- RUN, evaluated each cycle in this order:
  - `run_s`=0 → HALT, `cpu_en`=0.
  - `bp_en` and `pc`==`bp_addr` and `first`=0 → BREAK, `cpu_en`=0, `bp_hit`←1.
  - Otherwise `cpu_en`=1 and `first`←0.
  - `first` guarantees that a run started at the breakpoint address executes that instruction.
  - `bp_hit` is cleared on entry to RUN.
  - `step_pulse` is ignored.
- BREAK
  - `cpu_en`=0.
  - `run_s`=0 → HALT.
  - Else `step_pulse` → STEP, which executes the breakpoint instruction.
  - Resuming free-run requires `sw_run` to go low and then high again.

**Outputs**
- `cpu_en` is combinational from state, `run_s`, `first` and the breakpoint compare. The stop decision uses the PC of the instruction that would execute.
- `instret` increments by 1 on every `cpu_en`=1 cycle and wraps modulo 2^CNT_W.
- `halted` = (state==HALT) | (state==BREAK).

## Timing
**Reset values:** state=HALT, `cpu_en`=0, `halted`=1, `bp_hit`=0, `instret`=0, `first`=0. Synchronizers and debouncers reset to the released level (button 1, switch 0). Reset is asynchronous, so `cpu_en` drops in the same cycle `reset` falls, mid-run included.

**Latency**
- Raw input change to `run_s`/`step_pulse`: 2 + DEBOUNCE_CYCLES + 1 cycles.
- `step_pulse` → `cpu_en` high: the next cycle.
- `run_s` rising → first `cpu_en`: the next cycle. Thereafter one `cpu_en` per cycle, so throughput is 1 instruction/cycle.

**Breakpoint and stop behaviour**
- The breakpoint compare and `cpu_en` apply in the same cycle: the core halts with `pc`==`bp_addr` unexecuted.
- `run_s` falling stops enables in the cycle the debounced level falls. No partial instruction is possible (single-cycle core).
- A bounce shorter than DEBOUNCE_CYCLES produces no edge; one press yields exactly one step.

## Structure
- Package `run_ctrl_pkg`:
  - `run_state_t` enum (HALT, STEP, RUN, BREAK; 2-bit).
  - Default `DEBOUNCE_CYCLES` constant.
- Sub-module `input_debounce` (instantiated twice):
  - 2-FF synchronizer.
  - Stability counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Outputs: registered level plus rise and fall pulses.
- Top level: FSM, `first` flag, `bp_hit`, `instret`.

## Test plan
Simulation uses DEBOUNCE_CYCLES=16 and a PC model that does pc+=4 on `cpu_en`, starting at 0.
1. **Reset:** hold `reset`=0 for 5 cycles → state=0, `halted`=1, `cpu_en`=0, `instret`=0, `bp_hit`=0. Then assert `reset`=0 during RUN → `cpu_en` falls in the same cycle.
2. **Bouncing step:** toggle `btn_step_n` 6× at 3-cycle spacing, then hold it low for 40 cycles → exactly one `cpu_en` pulse, `instret`=1, pc=4. Release, then press cleanly again → `instret`=2, pc=8.
3. **Free-run:** `sw_run`=1 → `cpu_en` continuous, `instret` increments by 1/cycle. `sw_run`=0 → `cpu_en`=0 exactly 19 cycles after the raw change; state=HALT.
4. **Breakpoint:** `bp_en`=1, `bp_addr`=0x10, run from pc=0 → stop at pc=0x10, `instret`=4, state=BREAK, `bp_hit`=1. Then press step → pc=0x14, `bp_hit`=0, state=HALT, and the run switch still high does not restart RUN until it is toggled.
5. **Start on breakpoint:** pc=0x10, `bp_addr`=0x10, run → the first cycle has `cpu_en`=1, pc→0x14, no BREAK.
6. **Counter wrap:** CNT_W=4, 17 steps → `instret`=1.
